// File: rtl/spi_master_if.sv
// -----------------------------------------------------------------------------
// spi_master_if
//
// Bundles the host-side request/stream handshake and the four SPI pins of
// spi_master into one interface.
//   master modport : the spi_master side (drives SPI pins, status, strobes)
//   slave  modport : the host/harness side (drives requests, tx bytes, MISO)
//
// Parameters
//   LenBits : width of the payload byte count carried on len
// -----------------------------------------------------------------------------
interface spi_master_if #(
  parameter int LenBits = 12
);
  // Host request / status
  logic               start;
  logic [7:0]         cmd;
  logic [LenBits-1:0] len;
  logic               busy;
  logic               done;

  // Payload byte streams
  logic [7:0]         txData;
  logic               txReq;
  logic [7:0]         rxData;
  logic               rxValid;

  // SPI pins
  logic               SPI_CLK;
  logic               SPI_SS;
  logic               SPI_MOSI;
  logic               SPI_MISO;

  modport master (
    input  start, cmd, len, txData, SPI_MISO,
    output busy, done, txReq, rxData, rxValid, SPI_CLK, SPI_SS, SPI_MOSI
  );

  modport slave (
    output start, cmd, len, txData, SPI_MISO,
    input  busy, done, txReq, rxData, rxValid, SPI_CLK, SPI_SS, SPI_MOSI
  );
endinterface

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// SPI mode-0 master. One framed transaction per accepted start: SS drops, a
// command byte is shifted out, then len full-duplex payload bytes follow.
// Transmit bytes come from a show-ahead source (txData valid while txReq
// pops it); received payload bytes leave on rxData with an rxValid strobe.
// SCK half-period is ClkDiv SysClk cycles so a slave with 2-flop input
// synchronizers and an edge detector sees every edge with margin.
//
// Ports
//   SysClk   : single rising-edge clock
//   Reset_n  : asynchronous active-low reset
//   loopback : (only with SPIM_LOOPBACK_EN) sample registered MOSI as MISO
//   bus      : spi_master_if.master - start/cmd/len/busy/done,
//              txData/txReq, rxData/rxValid, SPI_CLK/SPI_SS/SPI_MOSI/SPI_MISO
//
// Configuration macro
//   SPIM_LOOPBACK_EN : adds the loopback input for slave-less self-test
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int ClkDiv  = 4,   // SysClk cycles per SCK half-period, >= 4
  parameter int LenBits = 12,
  parameter int SsGap   = 8    // minimum SS-high cycles between transactions
) (
  input  logic         SysClk,
  input  logic         Reset_n,
`ifdef SPIM_LOOPBACK_EN
  input  logic         loopback,
`endif
  spi_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  // One counter serves both the SCK half-period and the SS gap.
  localparam int CntMax = (ClkDiv > SsGap) ? ClkDiv : SsGap;
  localparam int CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DivLast    = CntW'(ClkDiv - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(SsGap - 1);
  localparam logic [CntW-1:0] GapPreLast = CntW'(SsGap - 2);

  state_t             state;
  logic [CntW-1:0]    cnt;
  logic [7:0]         shift;
  logic [2:0]         bit_cnt;
  logic [LenBits-1:0] byte_cnt;
  logic               payload;   // byte in flight is payload, not cmd
  logic               last;      // final bit of the frame is in flight

  logic               sck;
  logic               ss;
  logic               mosi;
  logic               busy;
  logic               done;
  logic               tx_req;
  logic [7:0]         rx_data;
  logic               rx_valid;

  logic               miso_bit;

`ifdef SPIM_LOOPBACK_EN
  assign miso_bit = loopback ? mosi : bus.SPI_MISO;
`else
  assign miso_bit = bus.SPI_MISO;
`endif

  logic half_end;
  assign half_end = (cnt == DivLast);

  always_ff @(posedge SysClk or negedge Reset_n) begin
    if (!Reset_n) begin
      // NOTE: every register, including the shift/data path, is reset here so
      // an abort mid-byte leaves no stale partial byte and all pins go idle
      // without waiting for a clock edge.
      state    <= IDLE;
      cnt      <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      payload  <= 1'b0;
      last     <= 1'b0;
      sck      <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx_req   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults for the one-cycle strobes; later
      // assignments in the case below override them for this edge only.
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETUP;
            cnt      <= '0;
            shift    <= bus.cmd;
            bit_cnt  <= 3'd7;
            byte_cnt <= bus.len;
            payload  <= 1'b0;
            last     <= 1'b0;
            ss       <= 1'b0;
            mosi     <= bus.cmd[7];
            busy     <= 1'b1;
          end
        end

        SETUP: begin
          if (half_end) begin
            state <= SHIFT_HI;
            cnt   <= '0;
            sck   <= 1'b1;
            // Sampled on the edge that raises SCK: the slave only changes
            // MISO after it has seen this rise.
            shift <= {shift[6:0], miso_bit};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (half_end) begin
            state <= SHIFT_LO;
            cnt   <= '0;
            sck   <= 1'b0;
            if (bit_cnt != 3'd0) begin
              bit_cnt <= bit_cnt - 1'b1;
              mosi    <= shift[7];
            end else begin
              if (payload) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
              end
              if (byte_cnt != '0) begin
                // txData is the head of the show-ahead source; it is popped
                // by tx_req in the following cycle.
                tx_req   <= 1'b1;
                shift    <= bus.txData;
                mosi     <= bus.txData[7];
                bit_cnt  <= 3'd7;
                byte_cnt <= byte_cnt - 1'b1;
                payload  <= 1'b1;
              end else begin
                mosi <= 1'b0;
                last <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SHIFT_LO: begin
          if (half_end) begin
            cnt <= '0;
            if (last) begin
              state <= HOLD;
            end else begin
              state <= SHIFT_HI;
              sck   <= 1'b1;
              shift <= {shift[6:0], miso_bit};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (half_end) begin
            state <= GAP;
            cnt   <= '0;
            ss    <= 1'b1;
            done  <= (SsGap == 1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt == GapLast) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt + 1'b1;
            // done lands on the last GAP cycle
            done <= (cnt == GapPreLast);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SPI_CLK  = sck;
  assign bus.SPI_SS   = ss;
  assign bus.SPI_MOSI = mosi;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.txReq    = tx_req;
  assign bus.rxData   = rx_data;
  assign bus.rxValid  = rx_valid;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Directed self-checking bench for spi_master with a small behavioural
// register-slave on the SPI pins. Slave command byte: [7]=register op,
// [6]=write(1)/read(0), [5:0]=address; four payload bytes MSB first.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int LEN_BITS = 12;
  localparam int SS_GAP   = 8;

  // {SS, SCK, MOSI, busy, done, txReq, rxValid, rxData}
  localparam logic [14:0] IDLE_OUTS = 15'h4000;

  logic SysClk  = 1'b0;
  logic Reset_n = 1'b1;
`ifdef SPIM_LOOPBACK_EN
  logic loopback = 1'b0;
`endif

  spi_master_if #(.LenBits(LEN_BITS)) bus ();

  spi_master #(
    .ClkDiv (CLK_DIV),
    .LenBits(LEN_BITS),
    .SsGap  (SS_GAP)
  ) dut (
    .SysClk  (SysClk),
    .Reset_n (Reset_n),
`ifdef SPIM_LOOPBACK_EN
    .loopback(loopback),
`endif
    .bus     (bus)
  );

  always #5 SysClk = ~SysClk;

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------- monitor
  int          txreq_cnt     = 0;
  int          rxv_cnt       = 0;
  int          done_cnt      = 0;
  int          sck_rise_cnt  = 0;
  int          ss_low_cyc    = 0;
  int          busy_cyc      = 0;
  int          edge_err      = 0;
  int          out_chg_cnt   = 0;
  int          ss_high_run   = 0;
  int          last_high_run = 0;
  logic        sck_prev      = 1'b0;
  logic [14:0] outs_prev     = IDLE_OUTS;
  logic [7:0]  rx_log[$];
  logic [14:0] outs;

  assign outs = {bus.SPI_SS, bus.SPI_CLK, bus.SPI_MOSI, bus.busy, bus.done,
                 bus.txReq, bus.rxValid, bus.rxData};

  always @(negedge SysClk) begin
    if (bus.txReq) txreq_cnt++;
    if (bus.rxValid) begin
      rxv_cnt++;
      rx_log.push_back(bus.rxData);
    end
    if (bus.done) done_cnt++;
    if (bus.SPI_CLK && !sck_prev) sck_rise_cnt++;
    if (!bus.SPI_SS) ss_low_cyc++;
    if (bus.busy) busy_cyc++;
    // strobes must coincide with a falling SCK edge
    if ((bus.txReq || bus.rxValid) && !(sck_prev && !bus.SPI_CLK)) edge_err++;
    if (bus.SPI_SS) ss_high_run++;
    else if (ss_high_run > 0) begin
      last_high_run = ss_high_run;
      ss_high_run   = 0;
    end
    if (outs !== outs_prev) out_chg_cnt++;
    outs_prev = outs;
    sck_prev  = bus.SPI_CLK;
  end

  // ----------------------------------------------------------- tx source
  logic [7:0] tx_mem[4];
  int         tx_base = 0;
  assign bus.txData = tx_mem[2'(txreq_cnt - tx_base)];

  // ------------------------------------------------------- slave model
  int          s_rise  = 0;
  logic [7:0]  s_shift = '0;
  logic [7:0]  s_cmd   = '0;
  logic [31:0] s_word  = '0;
  logic [31:0] rd_data = '0;
  logic [31:0] wr_data = '0;
  logic [5:0]  wr_addr = '0;
  int          wr_cnt  = 0;

  always @(posedge bus.SPI_CLK or negedge bus.SPI_SS) begin
    if (!bus.SPI_CLK) begin
      s_rise       = 0;
      bus.SPI_MISO = 1'b0;
    end else begin
      s_shift = {s_shift[6:0], bus.SPI_MOSI};
      if (s_rise == 7) s_cmd = s_shift;
      if (s_rise >= 8 && s_rise < 40) s_word = {s_word[30:0], bus.SPI_MOSI};
      if (s_rise == 39 && s_cmd[7:6] == 2'b11) begin
        wr_cnt++;
        wr_addr = s_cmd[5:0];
        wr_data = s_word;
      end
      s_rise++;
      if (s_rise >= 8 && s_rise < 40 && s_cmd[7:6] == 2'b10)
        bus.SPI_MISO = rd_data[39 - s_rise];
      else
        bus.SPI_MISO = 1'b0;
    end
  end

  // ------------------------------------------------------------- helpers
  int b_txreq, b_rxv, b_done, b_rise, b_sslow, b_busy, b_wr, b_rxlog;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge SysClk);
    #1;
  endtask

  task automatic snap();
    b_txreq = txreq_cnt;
    b_rxv   = rxv_cnt;
    b_done  = done_cnt;
    b_rise  = sck_rise_cnt;
    b_sslow = ss_low_cyc;
    b_busy  = busy_cyc;
    b_wr    = wr_cnt;
    b_rxlog = rx_log.size();
  endtask

  task automatic start_txn(input logic [7:0] c, input int n);
    tx_base   = txreq_cnt;
    bus.cmd   = c;
    bus.len   = LEN_BITS'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Returns in the cycle done is high (or after the budget runs out).
  task automatic wait_done(input string tag, input int n);
    int budget;
    bit seen;
    budget = CLK_DIV * (2 + 16 * (n + 1)) + SS_GAP + 20;
    seen   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (i < rx_log.size()) ? 32'(rx_log[i]) : 32'hFFFF_FFFF;
  endfunction

  // ------------------------------------------------------------ stimulus
  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.cmd   = '0;
    bus.len   = '0;
    for (int i = 0; i < 4; i++) tx_mem[i] = 8'h00;

    // Reset values
    #2 Reset_n = 1'b0;
    #1 check("reset_outs", 32'(outs), 32'(IDLE_OUTS));
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    snap();
    b_busy = out_chg_cnt;
    repeat (100) tick();
    check("idle_no_change", 32'(out_chg_cnt - b_busy), 32'd0);
    check("idle_outs", 32'(outs), 32'(IDLE_OUTS));

    // Register write 0xDEADBEEF to address 1
    tx_mem[0] = 8'hDE; tx_mem[1] = 8'hAD; tx_mem[2] = 8'hBE; tx_mem[3] = 8'hEF;
    snap();
    start_txn(8'hC1, 4);
    wait_done("wr", 4);
    tick();
    check("wr_txreq", 32'(txreq_cnt - b_txreq), 32'd4);
    check("wr_ss_low", 32'(ss_low_cyc - b_sslow), 32'(CLK_DIV * (2 + 16 * 5)));
    check("wr_busy", 32'(busy_cyc - b_busy), 32'(CLK_DIV * (2 + 16 * 5) + SS_GAP));
    check("wr_cmd", 32'(s_cmd), 32'hC1);
    check("wr_regwrite_cnt", 32'(wr_cnt - b_wr), 32'd1);
    check("wr_addr", 32'(wr_addr), 32'd1);
    check("wr_data", wr_data, 32'hDEAD_BEEF);
    check("wr_done_cnt", 32'(done_cnt - b_done), 32'd1);
    check("wr_busy_low", 32'(bus.busy), 32'd0);

    // Register read from address 1
    rd_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) tx_mem[i] = 8'h00;
    snap();
    start_txn(8'h81, 4);
    wait_done("rd", 4);
    tick();
    check("rd_rxvalid", 32'(rxv_cnt - b_rxv), 32'd4);
    check("rd_byte0", rx_at(b_rxlog + 0), 32'h12);
    check("rd_byte1", rx_at(b_rxlog + 1), 32'h34);
    check("rd_byte2", rx_at(b_rxlog + 2), 32'h56);
    check("rd_byte3", rx_at(b_rxlog + 3), 32'h78);
    check("rd_done_cnt", 32'(done_cnt - b_done), 32'd1);

    // Command only
    snap();
    start_txn(8'h05, 0);
    wait_done("co", 0);
    tick();
    check("co_sck_rises", 32'(sck_rise_cnt - b_rise), 32'd8);
    check("co_mosi", 32'(s_cmd), 32'h05);
    check("co_txreq", 32'(txreq_cnt - b_txreq), 32'd0);
    check("co_rxvalid", 32'(rxv_cnt - b_rxv), 32'd0);
    check("co_busy", 32'(busy_cyc - b_busy), 32'(CLK_DIV * 18 + SS_GAP));

    // start while busy is ignored
    tx_mem[0] = 8'h3C;
    snap();
    start_txn(8'hC1, 1);
    repeat (50) tick();
    bus.cmd = 8'h05; bus.len = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("ign", 1);
    check("ign_sck_rises", 32'(sck_rise_cnt - b_rise), 32'd16);
    check("ign_ss_low", 32'(ss_low_cyc - b_sslow), 32'(CLK_DIV * 34));
    check("ign_cmd", 32'(s_cmd), 32'hC1);

    // start raised in the done cycle and held until accepted
    snap();
    bus.cmd = 8'h05; bus.len = '0; bus.start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!bus.SPI_SS) begin
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    check("gap_ss_refall", 32'(seen), 32'd1);
    check("gap_ss_high_min", 32'(last_high_run >= SS_GAP), 32'd1);
    wait_done("gap2", 0);
    tick();
    check("gap2_sck_rises", 32'(sck_rise_cnt - b_rise), 32'd8);

    // Reset after 3 payload bits
    rd_data = 32'hCAFE_F00D;
    tx_mem[0] = 8'h11; tx_mem[1] = 8'h22;
    snap();
    start_txn(8'h81, 2);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sck_rise_cnt - b_rise >= 11) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("rst_reach_bit3", 32'(seen), 32'd1);
    tick();
    Reset_n = 1'b0;
    #1 check("rst_outs_immediate", 32'(outs), 32'(IDLE_OUTS));
    tick();
    check("rst_no_rxvalid", 32'(rxv_cnt - b_rxv), 32'd0);
    Reset_n = 1'b1;
    tick();
    check("rst_idle_after", 32'(outs), 32'(IDLE_OUTS));

    // Normal transaction after the abort
    tx_mem[0] = 8'h5A;
    snap();
    start_txn(8'h03, 1);
    wait_done("post", 1);
    tick();
    check("post_txreq", 32'(txreq_cnt - b_txreq), 32'd1);
    check("post_rxvalid", 32'(rxv_cnt - b_rxv), 32'd1);
    check("post_rxdata", rx_at(b_rxlog), 32'h00);
    check("post_cmd", 32'(s_cmd), 32'h03);
    check("post_mosi_payload", 32'(s_word[7:0]), 32'h5A);
    check("post_ss_low", 32'(ss_low_cyc - b_sslow), 32'(CLK_DIV * 34));

`ifdef SPIM_LOOPBACK_EN
    loopback  = 1'b1;
    tx_mem[0] = 8'hA5;
    snap();
    start_txn(8'h03, 1);
    wait_done("lb", 1);
    tick();
    loopback = 1'b0;
    check("lb_rxvalid", 32'(rxv_cnt - b_rxv), 32'd1);
    check("lb_rxdata", rx_at(b_rxlog), 32'hA5);
`endif

    check("strobe_edge_align", 32'(edge_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
